// File: rtl/note_spawn_scheduler.sv
// Beat-driven note block scheduler: fetches each beat's lane mask from the chart ROM,
// allocates block slots from a fixed pool and moves active blocks down at level speed.
module note_spawn_scheduler #(
    parameter int NUM_SLOTS = 8,
    parameter int SONG_LEN  = 96,
    parameter int H_TOP     = 120,
    parameter int H_BOTTOM  = 720
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    restart,
    input  logic                    pause,
    input  logic [1:0]              level,
    input  logic                    beat_pulse,
    input  logic                    step_pulse,
    output logic                    chart_rd,
    output logic [6:0]              chart_addr,
    input  logic [3:0]              chart_data,
    output logic [NUM_SLOTS-1:0]    slot_active,
    output logic [2*NUM_SLOTS-1:0]  slot_lane,
    output logic [10*NUM_SLOTS-1:0] slot_h,
    output logic [6:0]              beat_cnt,
    output logic                    song_done,
    output logic                    miss_pulse,
    output logic                    overflow_pulse
);

    // state | meaning
    // IDLE  | waiting for an accepted beat (new or pending)
    // FETCH | chart_rd high, chart_addr holds the beat index
    // WAIT  | chart_data valid, captured into mask
    // ALLOC | one lane per cycle into the lowest free slot
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, ALLOC} state_t;

    state_t                 state;
    logic [3:0]             mask;
    logic                   pend_valid;
    logic [6:0]             pend_addr;

    logic                   beat_ok;
    logic                   step_ok;
    logic [NUM_SLOTS-1:0]   free_vec;
    logic [NUM_SLOTS-1:0]   free_onehot;
    logic                   alloc_en;
    logic [1:0]             lane_idx;
    logic [3:0]             mask_next;
    logic [NUM_SLOTS-1:0]   retire;
    logic [10:0]            step_sum [NUM_SLOTS];
    logic                   beat_drop;
    logic                   lane_drop;

    assign beat_ok     = beat_pulse & ~pause & (beat_cnt < 7'(SONG_LEN));
    assign step_ok     = step_pulse & ~pause;
    assign free_vec    = ~slot_active;
    // Isolates the lowest set bit: lowest-index free slot.
    assign free_onehot = free_vec & (~free_vec + 1'b1);
    assign alloc_en    = (state == ALLOC) && (|free_vec);
    assign beat_drop   = beat_ok && pend_valid && (state != IDLE);
    assign lane_drop   = (state == ALLOC) && !(|free_vec);
    assign mask_next   = mask & ~(4'b0001 << lane_idx);
    assign song_done   = (beat_cnt == 7'(SONG_LEN)) && !(|slot_active);

    always_comb begin
        lane_idx = 2'd0;
        for (int b = 3; b >= 0; b--) begin
            if (mask[b]) lane_idx = b[1:0];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            step_sum[i] = {1'b0, slot_h[10*i +: 10]} + {9'd0, level} + 11'd1;
            retire[i]   = step_ok && slot_active[i] && (step_sum[i] >= 11'(H_BOTTOM));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mask           <= '0;
            pend_valid     <= 1'b0;
            pend_addr      <= '0;
            chart_rd       <= 1'b0;
            chart_addr     <= '0;
            beat_cnt       <= '0;
            miss_pulse     <= 1'b0;
            overflow_pulse <= 1'b0;
            slot_active    <= '0;
            slot_lane      <= '0;
            slot_h         <= {NUM_SLOTS{10'(H_TOP)}};
        end else if (restart) begin
            state          <= IDLE;
            mask           <= '0;
            pend_valid     <= 1'b0;
            pend_addr      <= '0;
            chart_rd       <= 1'b0;
            chart_addr     <= '0;
            beat_cnt       <= '0;
            miss_pulse     <= 1'b0;
            overflow_pulse <= 1'b0;
            slot_active    <= '0;
            slot_lane      <= '0;
            slot_h         <= {NUM_SLOTS{10'(H_TOP)}};
        end else begin
            miss_pulse     <= |retire;
            overflow_pulse <= beat_drop | lane_drop;
            if (beat_ok) beat_cnt <= beat_cnt + 7'd1;

            case (state)
                IDLE: begin
                    if (pend_valid) begin
                        state      <= FETCH;
                        chart_rd   <= 1'b1;
                        chart_addr <= pend_addr;
                        pend_valid <= beat_ok;
                        if (beat_ok) pend_addr <= beat_cnt;
                    end else if (beat_ok) begin
                        state      <= FETCH;
                        chart_rd   <= 1'b1;
                        chart_addr <= beat_cnt;
                    end
                end
                FETCH: begin
                    chart_rd <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    mask  <= chart_data;
                    state <= (chart_data == 4'd0) ? IDLE : ALLOC;
                end
                ALLOC: begin
                    mask <= mask_next;
                    if (mask_next == 4'd0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (state != IDLE && beat_ok && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_addr  <= beat_cnt;
            end

            // Allocation only targets inactive slots, so it never races a step update.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (alloc_en && free_onehot[i]) begin
                    slot_active[i]        <= 1'b1;
                    slot_lane[2*i +: 2]   <= lane_idx;
                    slot_h[10*i +: 10]    <= 10'(H_TOP);
                end else if (retire[i]) begin
                    slot_active[i]        <= 1'b0;
                    slot_h[10*i +: 10]    <= 10'(H_TOP);
                end else if (step_ok && slot_active[i]) begin
                    slot_h[10*i +: 10]    <= step_sum[i][9:0];
                end
            end
        end
    end

endmodule
